// File: rtl/sprite_pkg.sv
// Shared defaults, derived widths and object-ID encoding for the sprite layer decoder.
package sprite_pkg;

   localparam int NUM_SPRITES_DEF = 4;
   localparam int IMG_SIZE_DEF    = 32;
   localparam int MAP_H_DEF       = 640;
   localparam int MAP_V_DEF       = 480;
   localparam int H_WIDTH_DEF     = 10;
   localparam int V_WIDTH_DEF     = 10;

   localparam int ID_WIDTH    = $clog2(NUM_SPRITES_DEF + 1);
   localparam int INDEX_WIDTH = $clog2(MAP_H_DEF * MAP_V_DEF);

   typedef logic [INDEX_WIDTH-1:0] pix_index_t;

   // Object 0 is the background map; sprite k reports as OBJ_SPRITE0 + k.
   typedef enum logic [ID_WIDTH-1:0] {
      OBJ_MAP     = ID_WIDTH'(0),
      OBJ_SPRITE0 = ID_WIDTH'(1)
   } obj_id_e;

   // Offset from the sprite centre coordinate to the first pixel of its window.
   function automatic int win_lo_ofs(input int map_len, input int img);
      return (map_len - img) / 2 + 1;
   endfunction

   // Offset from the sprite centre coordinate to the last pixel of its window.
   function automatic int win_hi_ofs(input int map_len, input int img);
      return (map_len + img) / 2;
   endfunction

   // Width of a local row/column offset inside a sprite image.
   function automatic int ofs_width(input int img);
      return (img > 1) ? $clog2(img) : 1;
   endfunction

endpackage

// File: rtl/sprite_window.sv
// One sprite's screen window, local offsets and opaque-hit decision.
// Bounds are kept two bits wider than the coordinates and signed, so a sprite
// hanging off any screen edge clips instead of wrapping around.
module sprite_window
   import sprite_pkg::*;
#(
   parameter int IMG_SIZE = IMG_SIZE_DEF,
   parameter int MAP_H    = MAP_H_DEF,
   parameter int MAP_V    = MAP_V_DEF,
   parameter int H_WIDTH  = H_WIDTH_DEF,
   parameter int V_WIDTH  = V_WIDTH_DEF,
   localparam int OFS_W   = ofs_width(IMG_SIZE)
)(
   input  logic                               i_en,
   input  logic [H_WIDTH-1:0]                 i_pos_x,
   input  logic [V_WIDTH-1:0]                 i_pos_y,
   input  logic [IMG_SIZE-1:0][IMG_SIZE-1:0]  i_opacity,
   input  logic [H_WIDTH-1:0]                 i_h,
   input  logic [V_WIDTH-1:0]                 i_v,
   output logic                               o_hit,
   output logic [OFS_W-1:0]                   o_row,
   output logic [OFS_W-1:0]                   o_col
);

   localparam int HW = H_WIDTH + 2;
   localparam int VW = V_WIDTH + 2;

   localparam logic signed [HW-1:0] H_LO = HW'(win_lo_ofs(MAP_H, IMG_SIZE));
   localparam logic signed [HW-1:0] H_HI = HW'(win_hi_ofs(MAP_H, IMG_SIZE));
   localparam logic signed [VW-1:0] V_LO = VW'(win_lo_ofs(MAP_V, IMG_SIZE));
   localparam logic signed [VW-1:0] V_HI = VW'(win_hi_ofs(MAP_V, IMG_SIZE));

   logic signed [HW-1:0] w_x, w_h, w_hmin, w_hmax;
   logic signed [VW-1:0] w_y, w_v, w_vmin, w_vmax;
   logic                 w_inside;

   assign w_x    = {{2{i_pos_x[H_WIDTH-1]}}, i_pos_x};
   assign w_y    = {{2{i_pos_y[V_WIDTH-1]}}, i_pos_y};
   assign w_h    = {2'b00, i_h};
   assign w_v    = {2'b00, i_v};

   // Screen y grows downward while sprite y grows upward, hence the negation.
   assign w_hmin = w_x + H_LO;
   assign w_hmax = w_x + H_HI;
   assign w_vmin = V_LO - w_y;
   assign w_vmax = V_HI - w_y;

   assign w_inside = (w_h >= w_hmin) && (w_h <= w_hmax) &&
                     (w_v >= w_vmin) && (w_v <= w_vmax);

   assign o_col = OFS_W'(w_h - w_hmin);
   assign o_row = OFS_W'(w_v - w_vmin);

   // Opacity bit 1 means transparent, so only a 0 bit counts as a hit.
   assign o_hit = i_en & w_inside & ~i_opacity[o_row][o_col];

endmodule

// File: rtl/sprite_layer_decoder.sv
// Sprite layer decoder: resolves which object (map or sprite) owns each pixel
// and the index into that object's image, in a fixed two-stage pipeline.
// Sprite positions/enables are shadowed and committed on i_frame_start.
// Optional build macro SPRITE_COLLISION_EN adds per-frame collision flags;
// without it o_collision is tied to zero.
module sprite_layer_decoder
   import sprite_pkg::*;
#(
   parameter int NUM_SPRITES = NUM_SPRITES_DEF,
   parameter int IMG_SIZE    = IMG_SIZE_DEF,
   parameter int MAP_H       = MAP_H_DEF,
   parameter int MAP_V       = MAP_V_DEF,
   parameter int H_WIDTH     = H_WIDTH_DEF,
   parameter int V_WIDTH     = V_WIDTH_DEF,
   localparam int ID_W       = $clog2(NUM_SPRITES + 1),
   localparam int IDX_W      = $clog2(MAP_H * MAP_V)
)(
   input  logic                                          i_clk,
   input  logic                                          i_rst,
   input  logic                                          i_frame_start,
   input  logic [NUM_SPRITES-1:0]                        i_sprite_en,
   input  logic [NUM_SPRITES-1:0][H_WIDTH-1:0]           i_pos_x,
   input  logic [NUM_SPRITES-1:0][V_WIDTH-1:0]           i_pos_y,
   input  logic [NUM_SPRITES-1:0][IMG_SIZE-1:0][IMG_SIZE-1:0] i_opacity,
   input  logic                                          i_valid,
   input  logic [H_WIDTH-1:0]                            i_h,
   input  logic [V_WIDTH-1:0]                            i_v,
   output logic                                          o_valid,
   output logic [ID_W-1:0]                               o_object_id,
   output logic [IDX_W-1:0]                              o_pixel_index,
   output logic [NUM_SPRITES-1:0]                        o_collision
);

   localparam int OFS_W = ofs_width(IMG_SIZE);
   localparam logic [IDX_W-1:0] MAP_H_L = IDX_W'(MAP_H);
   localparam logic [IDX_W-1:0] IMG_L   = IDX_W'(IMG_SIZE);

   logic [NUM_SPRITES-1:0]              r_sh_en;
   logic [NUM_SPRITES-1:0][H_WIDTH-1:0] r_sh_x;
   logic [NUM_SPRITES-1:0][V_WIDTH-1:0] r_sh_y;

   logic [NUM_SPRITES-1:0]              w_hit;
   logic [NUM_SPRITES-1:0][OFS_W-1:0]   w_row;
   logic [NUM_SPRITES-1:0][OFS_W-1:0]   w_col;

   logic                                r1_valid;
   logic [H_WIDTH-1:0]                  r1_h;
   logic [V_WIDTH-1:0]                  r1_v;
   logic [NUM_SPRITES-1:0]              r1_hit;
   logic [NUM_SPRITES-1:0][OFS_W-1:0]   r1_row;
   logic [NUM_SPRITES-1:0][OFS_W-1:0]   r1_col;

   logic [ID_W-1:0]                     w_sel_id;
   logic [IDX_W-1:0]                    w_sel_idx;

   logic                                r2_valid;
   logic [ID_W-1:0]                     r2_id;
   logic [IDX_W-1:0]                    r2_idx;

   // Commit positions/enables at frame start; a pixel in the same cycle still sees the old copy.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sh_en <= '0;
         r_sh_x  <= '0;
         r_sh_y  <= '0;
      end else if (i_frame_start) begin
         r_sh_en <= i_sprite_en;
         r_sh_x  <= i_pos_x;
         r_sh_y  <= i_pos_y;
      end
   end

   genvar g;
   for (g = 0; g < NUM_SPRITES; g++) begin : g_win
      sprite_window #(
         .IMG_SIZE (IMG_SIZE),
         .MAP_H    (MAP_H),
         .MAP_V    (MAP_V),
         .H_WIDTH  (H_WIDTH),
         .V_WIDTH  (V_WIDTH)
      ) u_win (
         .i_en      (r_sh_en[g]),
         .i_pos_x   (r_sh_x[g]),
         .i_pos_y   (r_sh_y[g]),
         .i_opacity (i_opacity[g]),
         .i_h       (i_h),
         .i_v       (i_v),
         .o_hit     (w_hit[g]),
         .o_row     (w_row[g]),
         .o_col     (w_col[g])
      );
   end

   // Stage 1: capture the coordinate and every sprite's hit bit and local offset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r1_valid <= 1'b0;
         r1_h     <= '0;
         r1_v     <= '0;
         r1_hit   <= '0;
         r1_row   <= '0;
         r1_col   <= '0;
      end else begin
         r1_valid <= i_valid;
         r1_h     <= i_h;
         r1_v     <= i_v;
         r1_hit   <= w_hit;
         r1_row   <= w_row;
         r1_col   <= w_col;
      end
   end

   // Priority select: scanning from the top index down lets the lowest hit sprite win.
   always_comb begin
      w_sel_id  = ID_W'(OBJ_MAP);
      w_sel_idx = IDX_W'(r1_v) * MAP_H_L + IDX_W'(r1_h);
      for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
         if (r1_hit[k]) begin
            w_sel_id  = ID_W'(int'(OBJ_SPRITE0) + k);
            w_sel_idx = IDX_W'(r1_row[k]) * IMG_L + IDX_W'(r1_col[k]);
         end
      end
   end

   // Stage 2: register the selected object; id/index hold while no pixel is flowing.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r2_valid <= 1'b0;
         r2_id    <= '0;
         r2_idx   <= '0;
      end else begin
         r2_valid <= r1_valid;
         if (r1_valid) begin
            r2_id  <= w_sel_id;
            r2_idx <= w_sel_idx;
         end
      end
   end

   assign o_valid       = r2_valid;
   assign o_object_id   = r2_id;
   assign o_pixel_index = r2_idx;

`ifdef SPRITE_COLLISION_EN
   logic [NUM_SPRITES-1:0] r_coll_acc;
   logic [NUM_SPRITES-1:0] r_collision;
   logic [NUM_SPRITES-1:0] w_coll_now;

   // Two or more hit bits set means the stage-2 pixel is shared by several opaque sprites.
   assign w_coll_now = (r1_valid && ((r1_hit & (r1_hit - NUM_SPRITES'(1))) != '0)) ?
                       r1_hit : '0;

   // Accumulate over the frame; frame start publishes it, including the pixel in stage 2.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_coll_acc  <= '0;
         r_collision <= '0;
      end else if (i_frame_start) begin
         r_collision <= r_coll_acc | w_coll_now;
         r_coll_acc  <= '0;
      end else begin
         r_coll_acc  <= r_coll_acc | w_coll_now;
      end
   end

   assign o_collision = r_collision;
`else
   assign o_collision = '0;
`endif

endmodule
